// File: rtl/ex_stage_pipe_if.sv
// ex_stage_pipe_if: handshake and operand bus between the ID/EX register,
// the execute stage and the EX/MEM register.
interface ex_stage_pipe_if #(parameter int WIDTH = 64);
  logic             in_valid, in_ready;
  logic [WIDTH-1:0] ReadData1, ReadData2, PC, ALU_or_DT, BR_to_shift;
  logic [2:0]       ALUop;
  logic             ALUsrc, update, cbz_id, mul_op;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] alu_result, new_PC2;
  logic             negative, zero, overflow, carry_out, busy;

  modport master (
    output in_valid, ReadData1, ReadData2, PC, ALU_or_DT, BR_to_shift,
           ALUop, ALUsrc, update, cbz_id, mul_op, out_ready,
    input  in_ready, out_valid, alu_result, new_PC2,
           negative, zero, overflow, carry_out, busy
  );

  modport slave (
    input  in_valid, ReadData1, ReadData2, PC, ALU_or_DT, BR_to_shift,
           ALUop, ALUsrc, update, cbz_id, mul_op, out_ready,
    output in_ready, out_valid, alu_result, new_PC2,
           negative, zero, overflow, carry_out, busy
  );
endinterface

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage -- ALU with NZVC flag register, branch target
// adder, valid/ready output register. Define EX_MUL_EN to add the iterative
// shift-add multiplier (stalls the stage WIDTH+1 cycles per multiply).
module ex_stage_pipe #(
  parameter int WIDTH    = 64,
  parameter int BR_SHIFT = 2
) (
  input  logic           clk,
  input  logic           reset,
  ex_stage_pipe_if.slave bus
);
  logic [WIDTH-1:0] opa, opb, alu_res, npc;
  logic [WIDTH:0]   sum, dif;
  logic             alu_v, alu_c, out_free, accept, alu_load, busy;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d, npc_q, npc_d;
  logic             n_q, n_d, z_q, z_d, v_q, v_d, c_q, c_d, cbz_q, cbz_d;

`ifdef EX_MUL_EN
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [WIDTH-1:0] mpc_q, mpc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mupd_q, mupd_d, mcbz_q, mcbz_d, mul_load;
  assign busy = (state_q != S_IDLE);
`else
  logic unused_mul_op;
  assign unused_mul_op = bus.mul_op;
  assign busy          = 1'b0;
`endif

  assign opa      = bus.ReadData1;
  assign opb      = bus.ALUsrc ? bus.ALU_or_DT : bus.ReadData2;
  assign npc      = bus.PC + (bus.BR_to_shift << BR_SHIFT);
  assign out_free = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && bus.in_ready;

  assign bus.in_ready   = !busy && out_free;
  assign bus.busy       = busy;
  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.new_PC2    = npc_q;
  assign bus.negative   = n_q;
  assign bus.overflow   = v_q;
  assign bus.carry_out  = c_q;
  assign bus.zero       = cbz_q ? (result_q == '0) : z_q;

  // ALU: sub is A + ~B + 1 so C means "no borrow"
  always_comb begin
    sum     = {1'b0, opa} + {1'b0, opb};
    dif     = {1'b0, opa} + {1'b0, ~opb} + {{WIDTH{1'b0}}, 1'b1};
    alu_res = '0;
    alu_v   = 1'b0;
    alu_c   = 1'b0;
    case (bus.ALUop)
      3'b000: alu_res = opb;
      3'b010: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (opa[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b011: begin
        alu_res = dif[WIDTH-1:0];
        alu_c   = dif[WIDTH];
        alu_v   = (opa[WIDTH-1] != opb[WIDTH-1]) && (dif[WIDTH-1] != opa[WIDTH-1]);
      end
      3'b100:  alu_res = opa & opb;
      3'b101:  alu_res = opa | opb;
      3'b110:  alu_res = opa ^ opb;
      default: alu_res = '0;
    endcase
  end

  // Next state: output register, flags and (optionally) multiplier FSM
  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    npc_d       = npc_q;
    cbz_d       = cbz_q;
    n_d = n_q; z_d = z_q; v_d = v_q; c_d = c_q;
    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;
`ifdef EX_MUL_EN
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    mpc_d    = mpc_q;
    mupd_d   = mupd_q;
    mcbz_d   = mcbz_q;
    mul_load = 1'b0;
    case (state_q)
      S_IDLE: if (accept && bus.mul_op) begin
        state_d  = S_MUL;
        mcand_d  = opa;
        mplier_d = opb;
        prod_d   = '0;
        cnt_d    = '0;
        mpc_d    = npc;
        mupd_d   = bus.update;
        mcbz_d   = bus.cbz_id;
      end
      S_MUL: begin
        // one multiplier bit per cycle; bits above WIDTH fall off naturally
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_DONE;
      end
      S_DONE: if (out_free) begin
        state_d  = S_IDLE;
        mul_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    alu_load = accept && !bus.mul_op;
`else
    alu_load = accept;
`endif
    if (alu_load) begin
      out_valid_d = 1'b1;
      result_d    = alu_res;
      npc_d       = npc;
      cbz_d       = bus.cbz_id;
      if (bus.update) begin
        n_d = alu_res[WIDTH-1];
        z_d = (alu_res == '0);
        v_d = alu_v;
        c_d = alu_c;
      end
    end
`ifdef EX_MUL_EN
    if (mul_load) begin
      out_valid_d = 1'b1;
      result_d    = prod_q;
      npc_d       = mpc_q;
      cbz_d       = mcbz_q;
      if (mupd_q) begin
        n_d = prod_q[WIDTH-1];
        z_d = (prod_q == '0);
      end
    end
`endif
  end

  // State registers; reset also aborts an in-flight multiply
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      npc_q       <= '0;
      cbz_q       <= 1'b0;
      n_q <= 1'b0; z_q <= 1'b0; v_q <= 1'b0; c_q <= 1'b0;
`ifdef EX_MUL_EN
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      mpc_q    <= '0;
      mupd_q   <= 1'b0;
      mcbz_q   <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      npc_q       <= npc_d;
      cbz_q       <= cbz_d;
      n_q <= n_d; z_q <= z_d; v_q <= v_d; c_q <= c_d;
`ifdef EX_MUL_EN
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      mpc_q    <= mpc_d;
      mupd_q   <= mupd_d;
      mcbz_q   <= mcbz_d;
`endif
    end
  end
endmodule

// File: tb/tb_ex_stage_pipe.sv
// tb_ex_stage_pipe: table-driven vectors for the ALU/flags/branch adder,
// plus hand sequences for backpressure and (with EX_MUL_EN) the multiplier.
module tb_ex_stage_pipe;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ex_stage_pipe_if #(.WIDTH(64)) bus ();
  ex_stage_pipe #(.WIDTH(64), .BR_SHIFT(2)) dut (.clk(clk), .reset(reset), .bus(bus));

`ifdef EX_MUL_EN
  ex_stage_pipe_if #(.WIDTH(16)) bus16 ();
  ex_stage_pipe #(.WIDTH(16), .BR_SHIFT(2)) dut16 (.clk(clk), .reset(reset), .bus(bus16));
`endif

  typedef struct {
    logic [63:0] a, b, imm, pc, br;
    logic [2:0]  op;
    logic        src, upd, cbz;
    logic [63:0] res, npc;
    logic [3:0]  nzvc;
    logic        zero;
  } vec_t;
  vec_t tv[16];

  bit          mon_en = 1'b0;
  logic [63:0] got[$];

  always @(posedge clk)
    if (mon_en && bus.out_valid && bus.out_ready) got.push_back(bus.alu_result);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_pass(input logic [63:0] v);
    bus.ReadData1 = '0; bus.ReadData2 = v; bus.ALU_or_DT = '0;
    bus.ALUop = 3'b000; bus.ALUsrc = 1'b0; bus.update = 1'b0;
    bus.cbz_id = 1'b0; bus.mul_op = 1'b0; bus.in_valid = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    //        a                      b      imm      pc      br                     op     s  u  c  res                    npc    nzvc     z
    tv[0]  = '{64'h2AA,              64'h155, 64'h0, 64'h0,   64'h0,                 3'b010,1'b0,1'b0,1'b0,64'h3FF,         64'h0,  4'b0000,1'b0};
    tv[1]  = '{64'h7FFF_FFFF_FFFF_FFFF,64'h0, 64'h1, 64'h0,   64'h0,                 3'b010,1'b1,1'b1,1'b0,64'h8000_0000_0000_0000,64'h0,4'b1010,1'b0};
    tv[2]  = '{64'hF0,               64'h3C,  64'h0, 64'h0,   64'h0,                 3'b100,1'b0,1'b0,1'b0,64'h30,          64'h0,  4'b1010,1'b0};
    tv[3]  = '{64'h5,                64'h5,   64'h0, 64'h0,   64'h0,                 3'b011,1'b0,1'b1,1'b0,64'h0,           64'h0,  4'b0101,1'b1};
    tv[4]  = '{64'h0,                64'h3,   64'h0, 64'h0,   64'h0,                 3'b000,1'b0,1'b0,1'b1,64'h3,           64'h0,  4'b0101,1'b0};
    tv[5]  = '{64'h0,                64'h0,   64'h0, 64'h0,   64'h0,                 3'b000,1'b0,1'b0,1'b1,64'h0,           64'h0,  4'b0101,1'b1};
    tv[6]  = '{64'h1,                64'h0,   64'h0, 64'h0,   64'h0,                 3'b101,1'b0,1'b0,1'b0,64'h1,           64'h0,  4'b0101,1'b1};
    tv[7]  = '{64'h3,                64'h5,   64'h0, 64'h0,   64'h0,                 3'b011,1'b0,1'b1,1'b0,64'hFFFF_FFFF_FFFF_FFFE,64'h0,4'b1000,1'b0};
    tv[8]  = '{64'hFFFF_FFFF_FFFF_FFFF,64'h1, 64'h0, 64'h0,   64'h0,                 3'b010,1'b0,1'b1,1'b0,64'h0,           64'h0,  4'b0101,1'b1};
    tv[9]  = '{64'h8000_0000_0000_0000,64'h1, 64'h0, 64'h0,   64'h0,                 3'b011,1'b0,1'b1,1'b0,64'h7FFF_FFFF_FFFF_FFFF,64'h0,4'b0011,1'b0};
    tv[10] = '{64'hF0,               64'h0F,  64'h0, 64'h0,   64'h0,                 3'b101,1'b0,1'b1,1'b0,64'hFF,          64'h0,  4'b0000,1'b0};
    tv[11] = '{64'hFF,               64'hFF,  64'h0, 64'h0,   64'h0,                 3'b110,1'b0,1'b1,1'b0,64'h0,           64'h0,  4'b0100,1'b1};
    tv[12] = '{64'h1,                64'h1,   64'h0, 64'h100, 64'h80,                3'b001,1'b0,1'b1,1'b0,64'h0,           64'h300,4'b0100,1'b1};
    tv[13] = '{64'hFF00,             64'h0FF0,64'h0, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF,3'b110,1'b0,1'b1,1'b0,64'hF0F0,        64'hFC, 4'b0000,1'b0};
    tv[14] = '{64'h0,                64'h7,   64'h1234,64'h8, 64'h1,                 3'b000,1'b1,1'b1,1'b0,64'h1234,        64'hC,  4'b0000,1'b0};
    tv[15] = '{64'h8000_0000_0000_0000,64'h8000_0000_0000_0000,64'h0,64'h0,64'h0,    3'b010,1'b0,1'b1,1'b0,64'h0,           64'h0,  4'b0111,1'b1};

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.mul_op = 1'b0;
    bus.ReadData1 = '0; bus.ReadData2 = '0; bus.PC = '0; bus.ALU_or_DT = '0;
    bus.BR_to_shift = '0; bus.ALUop = '0; bus.ALUsrc = 1'b0; bus.update = 1'b0;
    bus.cbz_id = 1'b0;
`ifdef EX_MUL_EN
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1; bus16.mul_op = 1'b0;
    bus16.ReadData1 = '0; bus16.ReadData2 = '0; bus16.PC = '0; bus16.ALU_or_DT = '0;
    bus16.BR_to_shift = '0; bus16.ALUop = '0; bus16.ALUsrc = 1'b0; bus16.update = 1'b0;
    bus16.cbz_id = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // reset state
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.alu_result, 0);
    chk("rst_npc", bus.new_PC2, 0);
    chk("rst_nvcz", {bus.negative, bus.overflow, bus.carry_out, bus.zero}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_in_ready", bus.in_ready, 1);

    // table vectors, one per cycle, flags carry between rows
    for (int i = 0; i < 16; i++) begin
      bus.ReadData1 = tv[i].a; bus.ReadData2 = tv[i].b; bus.ALU_or_DT = tv[i].imm;
      bus.PC = tv[i].pc; bus.BR_to_shift = tv[i].br; bus.ALUop = tv[i].op;
      bus.ALUsrc = tv[i].src; bus.update = tv[i].upd; bus.cbz_id = tv[i].cbz;
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("vld[%0d]", i), bus.out_valid, 1);
      chk($sformatf("res[%0d]", i), bus.alu_result, tv[i].res);
      chk($sformatf("npc[%0d]", i), bus.new_PC2, tv[i].npc);
      chk($sformatf("nvc[%0d]", i), {bus.negative, bus.overflow, bus.carry_out},
          {tv[i].nzvc[3], tv[i].nzvc[1], tv[i].nzvc[0]});
      chk($sformatf("zero[%0d]", i), bus.zero, tv[i].zero);
    end
    bus.in_valid = 1'b0; bus.PC = '0; bus.BR_to_shift = '0;
    @(negedge clk);
    chk("drain_out_valid", bus.out_valid, 0);

    // backpressure: downstream stalls 3 cycles with a waiting instruction
    mon_en = 1'b1;
    drive_pass(64'h11);
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("stall_vld", bus.out_valid, 1);
    drive_pass(64'h22);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall_in_ready[%0d]", k), bus.in_ready, 0);
      chk($sformatf("stall_hold[%0d]", k), bus.alu_result, 64'h11);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    @(negedge clk);
    chk("b2b_res1", bus.alu_result, 64'h22);
    drive_pass(64'h33);
    @(negedge clk);
    chk("b2b_res2", bus.alu_result, 64'h33);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", bus.out_valid, 0);
    mon_en = 1'b0;
    chk("b2b_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b_q0", got[0], 64'h11);
      chk("b2b_q1", got[1], 64'h22);
      chk("b2b_q2", got[2], 64'h33);
    end

`ifndef EX_MUL_EN
    // without the multiplier, mul_op is ignored and the ALUop executes
    bus.ReadData1 = 64'd2; bus.ReadData2 = 64'd3; bus.ALUop = 3'b010;
    bus.ALUsrc = 1'b0; bus.update = 1'b0; bus.cbz_id = 1'b0;
    bus.mul_op = 1'b1; bus.in_valid = 1'b1;
    #1;
    chk("nomul_busy", bus.busy, 0);
    @(negedge clk);
    chk("nomul_vld", bus.out_valid, 1);
    chk("nomul_res", bus.alu_result, 64'd5);
    bus.in_valid = 1'b0; bus.mul_op = 1'b0;
    @(negedge clk);
`else
    // 16-bit multiply: WIDTH cycles in MUL, one in DONE
    bus16.ReadData1 = 16'h00FF; bus16.ReadData2 = 16'h0101; bus16.ALUsrc = 1'b0;
    bus16.ALUop = 3'b000; bus16.update = 1'b1; bus16.mul_op = 1'b1; bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0; bus16.mul_op = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("mul_busy[%0d]", k), bus16.busy, 1);
      chk($sformatf("mul_notvld[%0d]", k), bus16.out_valid, 0);
    end
    @(negedge clk);
    chk("mul_vld", bus16.out_valid, 1);
    chk("mul_res", bus16.alu_result, 16'hFFFF);
    chk("mul_n", bus16.negative, 1);
    chk("mul_busy_done", bus16.busy, 0);
    @(negedge clk);
    // reset mid-multiply
    bus16.mul_op = 1'b1; bus16.in_valid = 1'b1;
    @(negedge clk);
    bus16.in_valid = 1'b0; bus16.mul_op = 1'b0;
    repeat (4) @(negedge clk);
    chk("mul_busy_pre_rst", bus16.busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mul_rst_busy", bus16.busy, 0);
    chk("mul_rst_vld", bus16.out_valid, 0);
    reset = 1'b0;
    @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
